pe_comp_fsm_multilane: RTL

Parametrised PE computation controller, successor to the single-lane PE computation FSM. It sequences multi-layer W computation:
- start broadcast, drain the activation queue, pulse finish, wait for layer sync, flip the activation regfile direction, next layer.
- Issues LANES output activations per cycle with a tail lane mask.
- Adds datapath backpressure, optional zero-activation skipping and a synchronous abort.
- Sits between the PE activation queue and the PE MAC datapath, one instance per PE.

---
 rtl/pe_comp_fsm_multilane_pkg.sv | 25 ++
 rtl/pe_comp_fsm_multilane_if.sv | 30 +++
 rtl/pe_comp_fsm_multilane_group_ctr.sv | 47 ++++
 rtl/pe_comp_fsm_multilane.sv | 139 +++++++++++++
 4 files changed

// File: rtl/pe_comp_fsm_multilane_pkg.sv
// Shared types and constants for the multi-lane PE computation controller.
package pe_comp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRE_BC  = 2'd1,
    ST_POST_BC = 2'd2,
    ST_SYNC    = 2'd3
  } pe_state_e;

  localparam logic ACT_DIR_0 = 1'b0;
  localparam logic ACT_DIR_1 = 1'b1;

  localparam int PE_IDX_W_DEF   = 6;
  localparam int ACT_NO_W_DEF   = 8;
  localparam int LAYER_NO_W_DEF = 4;
  localparam int DATA_W_DEF     = 16;
  localparam int LANES_DEF      = 4;

  // Queue entries may only be consumed while the layer is broadcasting or draining.
  function automatic logic is_issue_state(input pe_state_e s);
    return (s == ST_PRE_BC) || (s == ST_POST_BC);
  endfunction

endpackage

// File: rtl/pe_comp_fsm_multilane_if.sv
// Activation queue / MAC datapath bundle seen by the PE computation controller.
interface pe_comp_fsm_multilane_if #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 16,
  parameter int ACT_NO_W = 8,
  parameter int LANES    = 4
);
  logic                     queue_empty;
  logic [ADDR_W+DATA_W-1:0] act_out;
  logic                     pop_act;
  logic                     comp_ready;
  logic                     comp_en;
  logic [LANES-1:0]         lane_mask;
  logic [ADDR_W-1:0]        in_act_idx;
  logic [DATA_W-1:0]        in_act_value;
  logic [ADDR_W-1:0]        out_act_base_idx;
  logic [ACT_NO_W-1:0]      out_act_addr;

  modport master (
    input  queue_empty, act_out, comp_ready,
    output pop_act, comp_en, lane_mask, in_act_idx, in_act_value,
           out_act_base_idx, out_act_addr
  );

  modport slave (
    output queue_empty, act_out, comp_ready,
    input  pop_act, comp_en, lane_mask, in_act_idx, in_act_value,
           out_act_base_idx, out_act_addr
  );
endinterface

// File: rtl/pe_comp_fsm_multilane_group_ctr.sv
// Output-activation group pointer: walks one queue entry across out_act_no outputs, LANES at a time.
module pe_out_act_group_ctr #(
  parameter int LANES    = 4,
  parameter int ACT_NO_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_advance,
  input  logic                i_clear,
  input  logic [ACT_NO_W-1:0] i_out_act_no,
  output logic [ACT_NO_W-1:0] o_grp_ptr,
  output logic [LANES-1:0]    o_lane_mask,
  output logic                o_last
);
  localparam int CW = ACT_NO_W + 1;

  logic [ACT_NO_W-1:0] r_grp_ptr;
  logic [CW-1:0]       w_ptr_ext;
  logic [CW-1:0]       w_no_ext;
  logic [CW-1:0]       w_next_ext;

  // One extra bit so grp_ptr+LANES cannot wrap near the top of the range.
  assign w_ptr_ext  = {1'b0, r_grp_ptr};
  assign w_no_ext   = {1'b0, i_out_act_no};
  assign w_next_ext = w_ptr_ext + CW'(LANES);

  always_comb begin
    o_lane_mask = '0;
    for (int l = 0; l < LANES; l++) begin
      o_lane_mask[l] = (w_ptr_ext + CW'(l)) < w_no_ext;
    end
  end

  assign o_last    = w_next_ext >= w_no_ext;
  assign o_grp_ptr = r_grp_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grp_ptr <= '0;
    end else if (i_clear) begin
      r_grp_ptr <= '0;
    end else if (i_advance) begin
      r_grp_ptr <= o_last ? '0 : w_next_ext[ACT_NO_W-1:0];
    end
  end

endmodule

// File: rtl/pe_comp_fsm_multilane.sv
// Per-PE multi-layer computation controller: broadcast, drain queue, sync, flip regfile, repeat.
module pe_comp_fsm_multilane #(
  parameter int PE_IDX_W   = 6,
  parameter int ACT_NO_W   = 8,
  parameter int LAYER_NO_W = 4,
  parameter int DATA_W     = 16,
  parameter int LANES      = 4,
  parameter int ADDR_W     = ACT_NO_W + PE_IDX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PE_IDX_W-1:0]   i_pe_idx,
  input  logic                  i_pe_start_calc,
  input  logic                  i_abort,
  input  logic                  i_skip_zero_en,
  input  logic [LAYER_NO_W-1:0] i_layer_no,
  input  logic [ACT_NO_W-1:0]   i_out_act_no,
  input  logic                  i_broadcast_done,
  input  logic                  i_comp_done,
  pe_comp_fsm_multilane_if.master act_if,
  output logic                  o_pe_start_broadcast,
  output logic                  o_fin_comp,
  output logic                  o_out_act_clear,
  output logic                  o_act_regfile_dir,
  output logic [LAYER_NO_W-1:0] o_layer_idx,
  output logic                  o_busy
);
  import pe_comp_pkg::*;

  pe_state_e             r_state;
  logic                  r_start_bc;
  logic                  r_act_clear;
  logic                  r_dir;
  logic [LAYER_NO_W-1:0] r_layer_idx;

  logic [ACT_NO_W-1:0]   w_grp_ptr;
  logic [LANES-1:0]      w_mask;
  logic                  w_last;
  logic [ADDR_W-1:0]     w_in_idx;
  logic [DATA_W-1:0]     w_value;
  logic [LAYER_NO_W-1:0] w_final_layer;
  logic                  w_issue_ok;
  logic                  w_skip;
  logic                  w_advance;
  logic                  w_start;
  logic                  w_layer_end;
  logic                  w_clear;

  assign {w_in_idx, w_value} = act_if.act_out;

  // A layer count of zero behaves as a single layer.
  assign w_final_layer = (i_layer_no == '0) ? '0 : i_layer_no - LAYER_NO_W'(1);

  assign w_issue_ok  = ~i_abort & is_issue_state(r_state) & ~act_if.queue_empty & act_if.comp_ready;
  assign w_skip      = i_skip_zero_en & (w_value == '0) & (w_grp_ptr == '0);
  assign w_advance   = w_issue_ok & ~w_skip;
  assign w_start     = (r_state == ST_IDLE) & i_pe_start_calc;
  assign w_layer_end = (r_state == ST_SYNC) & i_comp_done;
  assign w_clear     = i_abort | w_start | w_layer_end;

  pe_out_act_group_ctr #(
    .LANES    (LANES),
    .ACT_NO_W (ACT_NO_W)
  ) u_group_ctr (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_advance    (w_advance),
    .i_clear      (w_clear),
    .i_out_act_no (i_out_act_no),
    .o_grp_ptr    (w_grp_ptr),
    .o_lane_mask  (w_mask),
    .o_last       (w_last)
  );

  assign act_if.comp_en          = w_advance & (|w_mask);
  assign act_if.lane_mask        = w_advance ? w_mask : '0;
  assign act_if.pop_act          = w_issue_ok & (w_skip | w_last);
  assign act_if.in_act_idx       = w_in_idx;
  assign act_if.in_act_value     = w_value;
  assign act_if.out_act_base_idx = {w_grp_ptr, i_pe_idx};
  assign act_if.out_act_addr     = w_grp_ptr;

  assign o_fin_comp           = ~i_abort & (r_state == ST_POST_BC) & act_if.queue_empty;
  assign o_busy               = (r_state != ST_IDLE);
  assign o_pe_start_broadcast = r_start_bc;
  assign o_out_act_clear      = r_act_clear;
  assign o_act_regfile_dir    = r_dir;
  assign o_layer_idx          = r_layer_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_start_bc  <= 1'b0;
      r_act_clear <= 1'b0;
      r_dir       <= ACT_DIR_0;
      r_layer_idx <= '0;
    end else begin
      r_start_bc  <= 1'b0;
      r_act_clear <= 1'b0;
      if (i_abort) begin
        r_state     <= ST_IDLE;
        r_dir       <= ACT_DIR_0;
        r_layer_idx <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_pe_start_calc) begin
              r_state     <= ST_PRE_BC;
              r_layer_idx <= '0;
              r_start_bc  <= 1'b1;
              r_act_clear <= 1'b1;
            end
          end
          ST_PRE_BC: begin
            if (i_broadcast_done) r_state <= ST_POST_BC;
          end
          ST_POST_BC: begin
            if (act_if.queue_empty) r_state <= ST_SYNC;
          end
          ST_SYNC: begin
            if (i_comp_done) begin
              if (r_layer_idx == w_final_layer) begin
                r_state <= ST_IDLE;
              end else begin
                r_state     <= ST_PRE_BC;
                r_layer_idx <= r_layer_idx + LAYER_NO_W'(1);
                r_dir       <= ~r_dir;
                r_start_bc  <= 1'b1;
                r_act_clear <= 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
